// File: rtl/serial_align_pkg.sv
// rtl/serial_align_pkg.sv - shared types and constants for the serial word aligner
//   No ports. Holds:
//     state_t     FSM encoding HUNT=0, VERIFY=1, LOCKED=2 (3 is illegal)
//     COMMA_K28_5 alignment character, low byte of K28.5
//     *_W         counter and word widths
package serial_align_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [7:0] COMMA_K28_5 = 8'hBC;

   localparam int WORD_W     = 8;
   localparam int BIT_CNT_W  = 3;
   localparam int LINK_CNT_W = 4;   // good/miss counters, thresholds up to 15
   localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/serial_align_ctrl_if.sv
// rtl/serial_align_ctrl_if.sv - serial-in / aligned-word-out bundle of the aligner
//   DATA_IN     serial bit, first bit of a word first
//   ENABLE      bit-slot qualifier
//   DATA_OUT    last aligned word, first received bit in bit 0
//   DATA_VALID  one-cycle strobe per new word
//   IS_COMMA    DATA_OUT holds the comma, qualified by DATA_VALID
//   slave modport: the aligner; master modport: the bit source / word sink
interface serial_align_ctrl_if;
   import serial_align_pkg::*;

   logic              DATA_IN;
   logic              ENABLE;
   logic [WORD_W-1:0] DATA_OUT;
   logic              DATA_VALID;
   logic              IS_COMMA;

   modport slave (
      input  DATA_IN,
      input  ENABLE,
      output DATA_OUT,
      output DATA_VALID,
      output IS_COMMA
   );

   modport master (
      output DATA_IN,
      output ENABLE,
      input  DATA_OUT,
      input  DATA_VALID,
      input  IS_COMMA
   );

endinterface

// File: rtl/serial_shift_window.sv
// rtl/serial_shift_window.sv - 8-bit serial window with comma comparator
//   CLK        clock, rising edge
//   RESET      synchronous active-high reset, clears the window
//   enable     shift qualifier; window holds when low
//   data_in    serial bit
//   win_next   window including the bit sampled on this edge
//   comma_hit  win_next equals COMMA
module serial_shift_window
   import serial_align_pkg::*;
#(
   parameter logic [7:0] COMMA = COMMA_K28_5
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              enable,
   input  logic              data_in,
   output logic [WORD_W-1:0] win_next,
   output logic              comma_hit
);

   logic [WORD_W-1:0] win;

   // New bits enter at the top so that after eight shifts the first bit
   // of the word sits in bit 0.
   assign win_next  = {data_in, win[WORD_W-1:1]};
   assign comma_hit = (win_next == COMMA);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         win <= '0;
      end else if (enable) begin
         win <= win_next;
      end
   end

endmodule

// File: rtl/serial_align_ctrl.sv
// rtl/serial_align_ctrl.sv - comma-based word alignment controller
//   CLK      clock, rising edge
//   RESET    synchronous active-high reset
//   rx       serial_align_ctrl_if.slave: DATA_IN/ENABLE in, DATA_OUT/DATA_VALID/IS_COMMA out
//   LOCKED   high while in LOCKED
//   STATE    current FSM state (debug)
//   ERR_CNT  saturating lock-loss count, present only with SYNC_ERR_CNT_EN defined
module serial_align_ctrl #(
   parameter logic [7:0] COMMA      = serial_align_pkg::COMMA_K28_5,
   parameter int         LOCK_COUNT = 3,
   parameter int         LOSS_COUNT = 4
) (
   input  logic                      CLK,
   input  logic                      RESET,
   serial_align_ctrl_if.slave        rx,
   output logic                      LOCKED,
   output logic [1:0]                STATE
`ifdef SYNC_ERR_CNT_EN
   ,
   output logic [7:0]                ERR_CNT
`endif
);
   // Imported after the port list so the LOCKED port keeps its name; the
   // LOCKED state is always referenced through the package scope here.
   import serial_align_pkg::*;

   localparam logic [LINK_CNT_W-1:0] LOCK_N = LINK_CNT_W'(LOCK_COUNT);
   localparam logic [LINK_CNT_W-1:0] LOSS_N = LINK_CNT_W'(LOSS_COUNT);

   logic [WORD_W-1:0]     win_next;
   logic                  comma_hit;

   state_t                state_q,    state_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
   logic [LINK_CNT_W-1:0] good_q,     good_d;
   logic [LINK_CNT_W-1:0] miss_q,     miss_d;
   logic [WORD_W-1:0]     data_out_q, data_out_d;
   logic                  valid_q,    valid_d;
   logic                  is_comma_q, is_comma_d;
   logic                  boundary;

   serial_shift_window #(
      .COMMA (COMMA)
   ) u_window (
      .CLK       (CLK),
      .RESET     (RESET),
      .enable    (rx.ENABLE),
      .data_in   (rx.DATA_IN),
      .win_next  (win_next),
      .comma_hit (comma_hit)
   );

   // Only meaningful inside the ENABLE branch below.
   assign boundary = (bit_cnt_q == 3'd7);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= HUNT;
         bit_cnt_q  <= '0;
         good_q     <= '0;
         miss_q     <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         is_comma_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         good_q     <= good_d;
         miss_q     <= miss_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         is_comma_q <= is_comma_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      good_d     = good_q;
      miss_d     = miss_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      is_comma_d = 1'b0;

      if (rx.ENABLE) begin
         bit_cnt_d = bit_cnt_q + 3'd1;

         case (state_q)
            HUNT: begin
               // The comma completing on this edge defines bit 0 of the
               // next word, so the count restarts from zero.
               if (comma_hit) begin
                  bit_cnt_d = '0;
                  good_d    = 4'd1;
                  state_d   = VERIFY;
               end
            end

            VERIFY: begin
               if (boundary) begin
                  if (comma_hit) begin
                     good_d = good_q + 4'd1;
                     if (good_q + 4'd1 == LOCK_N) begin
                        miss_d  = '0;
                        state_d = serial_align_pkg::LOCKED;
                     end
                  end else begin
                     state_d = HUNT;
                  end
               end
            end

            serial_align_pkg::LOCKED: begin
               if (boundary) begin
                  data_out_d = win_next;
                  valid_d    = 1'b1;
                  is_comma_d = comma_hit;
                  if (comma_hit) begin
                     miss_d = '0;
                  end
               end else if (comma_hit) begin
                  miss_d = miss_q + 4'd1;
                  // The offending comma becomes the new alignment candidate
                  // instead of restarting the search from HUNT.
                  if (miss_q + 4'd1 == LOSS_N) begin
                     bit_cnt_d = '0;
                     good_d    = 4'd1;
                     state_d   = VERIFY;
                  end
               end
            end

            default: begin
               state_d = HUNT;
            end
         endcase
      end
   end

`ifdef SYNC_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         err_cnt_q <= '0;
      end else if (state_q == serial_align_pkg::LOCKED && state_d == VERIFY &&
                   err_cnt_q != 8'hFF) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign ERR_CNT = err_cnt_q;
`endif

   assign rx.DATA_OUT   = data_out_q;
   assign rx.DATA_VALID = valid_q;
   assign rx.IS_COMMA   = is_comma_q;
   assign LOCKED        = (state_q == serial_align_pkg::LOCKED);
   assign STATE         = state_q;

endmodule
